i2ss_rx: RTL and testbench



---
 rtl/i2ss_rx_if.sv | 11 +
 rtl/i2ss_rx.sv | 126 ++++++++++++
 tb/tb_i2ss_rx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/i2ss_rx_if.sv
// i2ss_rx_if: stereo sample port carrying one left/right pair per valid/ready handshake.
interface i2ss_rx_if #(
    parameter int DW = 24
);
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_left;
    logic [DW-1:0] o_right;
    modport master(output o_valid, o_left, o_right, input i_ready);
    modport slave(input o_valid, o_left, o_right, output i_ready);
endinterface

// File: rtl/i2ss_rx.sv
// i2ss_rx: I2S slave receiver delivering completed left/right pairs on a valid/ready port.
// Define I2SS_RX_SYNC_EN to put 2-flop synchronizers on sclk, lrclk and sdata.
module i2ss_rx #(
    parameter int DW = 24
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      en,
    input  logic      sclk,
    input  logic      lrclk,
    input  logic      sdata,
    input  logic      clr,
    output logic      o_ovf,
    output logic      o_ferr,
    i2ss_rx_if.master st
);
    localparam int CW = $clog2(DW) + 1;
    typedef enum logic [1:0] {IDLE, SYNC, WAIT_L, WAIT_R} state_t;
    state_t        state_q, state_d;
    logic          sclk_s, lr_s, sd_s;
    logic          sclk_prev_q, sclk_prev_d, lr_prev_q, lr_prev_d;
    logic          chan_q, chan_d, done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] shift_q, shift_d, left_q, left_d;
    logic [DW-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
    logic          valid_q, valid_d, ovf_q, ovf_d, ferr_q, ferr_d;
    logic          rise, bnd, active, short_slot, pair, load;

`ifdef I2SS_RX_SYNC_EN
    logic [2:0] meta_q, meta_d, sync_q, sync_d;
    assign meta_d = {sclk, lrclk, sdata};
    assign sync_d = meta_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end
    assign {sclk_s, lr_s, sd_s} = sync_q;
`else
    assign {sclk_s, lr_s, sd_s} = {sclk, lrclk, sdata};
`endif

    always_comb begin
        rise        = sclk_s & ~sclk_prev_q;
        bnd         = rise & (lr_s != lr_prev_q);
        active      = (state_q == WAIT_L) || (state_q == WAIT_R);
        short_slot  = active & bnd & (cnt_q != '0) & (cnt_q < CW'(DW));
        // done_q marks the cycle after a word filled; the right word is still in shift_q
        pair        = done_q & chan_q & (state_q == WAIT_R);
        load        = pair & (~valid_q | st.i_ready);
        sclk_prev_d = sclk_s;
        lr_prev_d   = rise ? lr_s : lr_prev_q;
        chan_d      = bnd ? lr_s : chan_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        if (!active || bnd) begin
            cnt_d = '0;
        end else if (rise && (cnt_q < CW'(DW))) begin
            shift_d = {shift_q[DW-2:0], sd_s};
            cnt_d   = cnt_q + 1'b1;
            done_d  = (cnt_q == CW'(DW - 1));
        end
        left_d  = (done_q & ~chan_q & active) ? shift_q : left_q;
        state_d = state_q;
        if (!en)
            state_d = IDLE;
        else if (state_q == IDLE)
            state_d = SYNC;
        else if (state_q == SYNC)
            state_d = (bnd & ~lr_s) ? WAIT_L : SYNC;
        else if (short_slot)
            state_d = WAIT_L;
        else if (state_q == WAIT_L)
            state_d = (done_q & ~chan_q) ? WAIT_R : WAIT_L;
        else
            state_d = pair ? WAIT_L : WAIT_R;
        valid_d = load | (valid_q & ~st.i_ready);
        out_l_d = load ? left_q : out_l_q;
        out_r_d = load ? shift_q : out_r_q;
        ovf_d   = (pair & ~load) | (ovf_q & ~clr);
        ferr_d  = short_slot | (ferr_q & ~clr);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            sclk_prev_q <= 1'b0;
            lr_prev_q   <= 1'b0;
            chan_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            left_q      <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_prev_q <= sclk_prev_d;
            lr_prev_q   <= lr_prev_d;
            chan_q      <= chan_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            left_q      <= left_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
            ferr_q      <= ferr_d;
        end
    end

    assign st.o_valid = valid_q;
    assign st.o_left  = out_l_q;
    assign st.o_right = out_r_q;
    assign o_ovf      = ovf_q;
    assign o_ferr     = ferr_q;
endmodule

// File: tb/tb_i2ss_rx.sv
// tb_i2ss_rx: self-checking bench for i2ss_rx; frame table, corner-case sequences and
// randomized frames scored against a slot-length model of which pairs must appear.
`timescale 1ns/1ps
module tb_i2ss_rx;
    localparam int DW = 24;
`ifdef I2SS_RX_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif
    typedef struct packed {logic [DW-1:0] l; logic [DW-1:0] r;} pair_t;
    typedef struct {logic [DW-1:0] l; logic [DW-1:0] r; int rlen; int npair; logic ferr;} vec_t;

    logic  clk = 0, rstn = 0, en = 0, sclk = 0, lrclk = 0, sdata = 0, clr = 0;
    logic  o_ovf, o_ferr;
    logic  carry = 0, prev_v = 0, rnd_rdy = 0, rnd_bit = 0, rdy_val = 1;
    int    cyc = 0, lsb_cyc = 0, vrise_cyc = 0, n_chk = 0, n_fail = 0;
    pair_t got[$], exp_q[$];
    vec_t  tv[11];

    i2ss_rx_if #(.DW(DW)) bus();
    i2ss_rx #(.DW(DW)) dut (
        .clk(clk), .rstn(rstn), .en(en), .sclk(sclk), .lrclk(lrclk), .sdata(sdata),
        .clr(clr), .o_ovf(o_ovf), .o_ferr(o_ferr), .st(bus)
    );

    assign bus.i_ready = rnd_rdy ? rnd_bit : rdy_val;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(negedge clk);
        if (bus.o_valid && bus.i_ready) got.push_back({bus.o_left, bus.o_right});
        if (bus.o_valid && !prev_v) vrise_cyc = cyc;
        prev_v = bus.o_valid;
    end

    initial forever begin
        @(posedge clk);
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // one sclk period = 8 clk; period 0 carries the previous slot's last bit
    task automatic send_slot(input logic lr, input logic [31:0] w, input int n, input int k0);
        logic [31:0] t;
        for (int k = k0; k < n; k++) begin
            @(posedge clk);
            #1;
            t = w << ((k == 0) ? 0 : k - 1);
            sclk = 0;
            lrclk = lr;
            sdata = (k == 0) ? carry : t[31];
            repeat (4) @(posedge clk);
            #1 sclk = 1;
            if (lr && k == DW) lsb_cyc = cyc;
            repeat (3) @(posedge clk);
        end
        t = w << (n - 1);
        carry = t[31];
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int llen, input int rlen);
        send_slot(1'b0, {l, 8'($urandom)}, llen, 0);
        send_slot(1'b1, {r, 8'($urandom)}, rlen, 0);
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr = 1;
        @(posedge clk);
        #1 clr = 0;
    endtask

    initial begin
        logic [31:0]   rw, fw;
        logic [DW-1:0] l, r;
        int            ll, rl;
        logic          eferr;
        tv[0] = '{24'hA5A5A5, 24'h5A5A5A, 32, 1, 1'b0};
        tv[1] = '{24'h123456, 24'h654321, 16, 0, 1'b0};
        tv[2] = '{24'hABCDEF, 24'hFEDCBA, 32, 1, 1'b1};
        for (int i = 0; i < 8; i++) tv[3 + i] = '{24'(i + 1), 24'h800000 + 24'(i + 1), 32, 1, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.o_valid), 64'(0));
        chk("rst_left", 64'(bus.o_left), 64'(0));
        chk("rst_right", 64'(bus.o_right), 64'(0));
        chk("rst_ovf", 64'(o_ovf), 64'(0));
        chk("rst_ferr", 64'(o_ferr), 64'(0));
        rstn = 1;
        en = 1;
        send_slot(1'b1, $urandom, 32, 0);
        for (int i = 0; i < 11; i++) begin
            got.delete();
            send_frame(tv[i].l, tv[i].r, 32, tv[i].rlen);
            chk($sformatf("row%0d_npair", i), 64'(got.size()), 64'(tv[i].npair));
            if (got.size() == 1 && tv[i].npair == 1) begin
                chk($sformatf("row%0d_left", i), 64'(got[0].l), 64'(tv[i].l));
                chk($sformatf("row%0d_right", i), 64'(got[0].r), 64'(tv[i].r));
            end
            chk($sformatf("row%0d_ferr", i), 64'(o_ferr), 64'(tv[i].ferr));
            if (i == 0) chk("latency", 64'(vrise_cyc - lsb_cyc), 64'(LAT));
            if (tv[i].ferr) pulse_clr();
        end
        chk("b2b_ovf", 64'(o_ovf), 64'(0));

        rdy_val = 0;
        got.delete();
        send_frame(24'h111111, 24'h222222, 32, 32);
        chk("bp1_valid", 64'(bus.o_valid), 64'(1));
        chk("bp1_left", 64'(bus.o_left), 64'(24'h111111));
        chk("bp1_right", 64'(bus.o_right), 64'(24'h222222));
        chk("bp1_ovf", 64'(o_ovf), 64'(0));
        send_frame(24'h333333, 24'h444444, 32, 32);
        chk("bp2_valid", 64'(bus.o_valid), 64'(1));
        chk("bp2_left", 64'(bus.o_left), 64'(24'h111111));
        chk("bp2_right", 64'(bus.o_right), 64'(24'h222222));
        chk("bp2_ovf", 64'(o_ovf), 64'(1));
        @(posedge clk);
        #1 rdy_val = 1;
        clr = 1;
        @(posedge clk);
        #1 clr = 0;
        chk("bp_valid_after", 64'(bus.o_valid), 64'(0));
        chk("bp_ovf_after", 64'(o_ovf), 64'(0));
        chk("bp_accepted", 64'(got.size()), 64'(1));

        @(posedge clk);
        #1 en = 0;
        got.delete();
        rw = $urandom;
        send_slot(1'b0, $urandom, 32, 0);
        send_slot(1'b1, rw, 10, 0);
        en = 1;
        send_slot(1'b1, rw, 32, 10);
        send_frame(24'hC0FFEE, 24'hBEEF01, 32, 32);
        chk("mid_npair", 64'(got.size()), 64'(1));
        if (got.size() == 1) chk("mid_pair", 64'(got[0]), 64'({24'hC0FFEE, 24'hBEEF01}));

        rdy_val = 0;
        send_frame(24'h5EED01, 24'h5EED02, 32, 32);
        chk("rst_pre_valid", 64'(bus.o_valid), 64'(1));
        fw = $urandom;
        send_slot(1'b0, fw, 11, 0);
        #1 rstn = 0;
        #1;
        chk("mid_rst_valid", 64'(bus.o_valid), 64'(0));
        chk("mid_rst_left", 64'(bus.o_left), 64'(0));
        chk("mid_rst_right", 64'(bus.o_right), 64'(0));
        chk("mid_rst_ovf", 64'(o_ovf), 64'(0));
        chk("mid_rst_ferr", 64'(o_ferr), 64'(0));
        @(posedge clk);
        #1 rstn = 1;
        rdy_val = 1;
        got.delete();
        send_slot(1'b0, fw, 32, 11);
        send_slot(1'b1, $urandom, 32, 0);
        send_frame(24'h0DD123, 24'h0DD456, 32, 32);
        chk("post_rst_npair", 64'(got.size()), 64'(1));
        if (got.size() == 1) chk("post_rst_pair", 64'(got[0]), 64'({24'h0DD123, 24'h0DD456}));

        pulse_clr();
        got.delete();
        exp_q.delete();
        eferr = 0;
        rnd_rdy = 1;
        for (int f = 0; f < 24; f++) begin
            l = 24'($urandom);
            r = 24'($urandom);
            ll = (f < 23 && $urandom_range(0, 7) == 0) ? int'($urandom_range(8, 20)) : 32;
            rl = (f < 23 && $urandom_range(0, 7) == 0) ? int'($urandom_range(8, 20)) : 32;
            // a slot of n sclk periods carries n-1 data bits after its boundary
            if (ll - 1 >= DW && rl - 1 >= DW) exp_q.push_back({l, r});
            if (ll - 1 < DW || rl - 1 < DW) eferr = 1;
            send_frame(l, r, ll, rl);
        end
        rnd_rdy = 0;
        rdy_val = 1;
        repeat (20) @(posedge clk);
        #1;
        chk("rnd_count", 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("rnd_pair%0d", i), 64'(got[i]), 64'(exp_q[i]));
        chk("rnd_ferr", 64'(o_ferr), 64'(eferr));
        chk("rnd_ovf", 64'(o_ovf), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
